// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver. It synchronizes rx and centre-samples each bit.
// Each good byte is presented with a 2-cycle byte_available pulse.
module uart_byte_receiver #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_available,
    output logic       framing_error,
    output logic       busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t      state;
    logic        rx_m, rx_s;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            hold_cnt       <= 1'b0;
            byte_out       <= '0;
            byte_available <= 1'b0;
            framing_error  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            // The pulse stretcher is independent of the FSM, so a new start bit can begin while it is still high.
            if (hold_cnt)
                hold_cnt <= 1'b0;
            else
                byte_available <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_M1) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_M1) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_cnt == BIT_M1) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            byte_out       <= shreg;
                            byte_available <= 1'b1;
                            hold_cnt       <= 1'b1;
                            state          <= IDLE;
                            busy           <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                BREAK: begin
                    // A held-low line must go high before a new start bit can be seen.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver with two instances, CLKS_PER_BIT=16 (index 0) and CLKS_PER_BIT=4 (index 1).
// A negedge monitor logs byte_available and framing_error pulses so the checks can run after the fact.
module tb_uart_byte_receiver;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rx16 = 1'b1;
    logic            rx4 = 1'b1;
    logic [1:0][7:0] bo;
    logic [1:0]      ba, fe, bsy;

    always #5 clk = ~clk;

    uart_byte_receiver #(.CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst(rst), .rx(rx16),
        .byte_out(bo[0]), .byte_available(ba[0]), .framing_error(fe[0]), .busy(bsy[0]));

    uart_byte_receiver #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .rx(rx4),
        .byte_out(bo[1]), .byte_available(ba[1]), .framing_error(fe[1]), .busy(bsy[1]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         nrise[2]   = '{0, 0};
    int         rise_cyc[2][16];
    logic [7:0] rise_byte[2][16];
    int         width[2][16];
    int         hi_run[2]  = '{0, 0};
    int         low_run[2] = '{0, 0};
    int         min_gap[2] = '{1000, 1000};
    int         fe_rise[2] = '{0, 0};
    int         fe_cyc[2]  = '{0, 0};
    logic [1:0] ba_prev = '0;
    logic [1:0] fe_prev = '0;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ba_prev[k] <= ba[k];
            fe_prev[k] <= fe[k];
            if (ba[k] && !ba_prev[k]) begin
                if (nrise[k] > 0 && low_run[k] < min_gap[k]) min_gap[k] <= low_run[k];
                rise_cyc[k][nrise[k] & 15]  <= cyc;
                rise_byte[k][nrise[k] & 15] <= bo[k];
                nrise[k] <= nrise[k] + 1;
                hi_run[k] <= 1;
            end else if (ba[k]) begin
                hi_run[k] <= hi_run[k] + 1;
            end
            if (!ba[k] && ba_prev[k]) width[k][(nrise[k] - 1) & 15] <= hi_run[k];
            low_run[k] <= ba[k] ? 0 : low_run[k] + 1;
            if (fe[k]) fe_cyc[k] <= fe_cyc[k] + 1;
            if (fe[k] && !fe_prev[k]) fe_rise[k] <= fe_rise[k] + 1;
        end
    end

    int total  = 0;
    int passed = 0;
    int start_cyc[2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input int k, input logic v, input int cpb);
        if (k == 0) rx16 = v;
        else rx4 = v;
        tick(cpb);
    endtask

    task automatic send_frame(input int k, input int cpb, input logic [7:0] d, input logic stop);
        start_cyc[k] = cyc;
        drive_bit(k, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_bit(k, d[i], cpb);
        drive_bit(k, stop, cpb);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_pulses;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    // Rising edge of byte_available, counted from the negedge that drives the start bit:
    // 1 to the first sampling edge, 2 for the synchronizer, then HALF + 9*CLKS_PER_BIT.
    localparam int LAT16 = 1 + 2 + 8 + 9 * 16;

    initial begin
        vec_t tbl[5];
        int   b, f, fc;

        tbl[0] = '{8'h4C, 1'b1, 1, 8'h4C, 0};
        tbl[1] = '{8'h81, 1'b1, 1, 8'h81, 0};
        tbl[2] = '{8'h5A, 1'b0, 0, 8'h81, 1};
        tbl[3] = '{8'hFE, 1'b1, 1, 8'hFE, 0};
        tbl[4] = '{8'h00, 1'b1, 1, 8'h00, 0};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_byte_out", int'(bo[k]), 0);
            chk("rst_avail", int'(ba[k]), 0);
            chk("rst_ferr", int'(fe[k]), 0);
            chk("rst_busy", int'(bsy[k]), 0);
        end
        rst = 1'b0;
        tick(10);

        for (int i = 0; i < 5; i++) begin
            b = nrise[0];
            f = fe_rise[0];
            send_frame(0, 16, tbl[i].data, tbl[i].stop);
            drive_bit(0, 1'b1, 20);
            chk("vec_pulses", nrise[0] - b, tbl[i].exp_pulses);
            chk("vec_byte_out", int'(bo[0]), int'(tbl[i].exp_byte));
            chk("vec_ferr", fe_rise[0] - f, tbl[i].exp_ferr);
            if (tbl[i].exp_pulses > 0) begin
                chk("vec_latency", rise_cyc[0][b & 15] - start_cyc[0], LAT16);
                chk("vec_width", width[0][b & 15], 2);
                chk("vec_byte_at_rise", int'(rise_byte[0][b & 15]), int'(tbl[i].exp_byte));
            end
        end

        // Back-to-back frames with no idle gap.
        b = nrise[0];
        send_frame(0, 16, 8'h4C, 1'b1);
        send_frame(0, 16, 8'h33, 1'b1);
        send_frame(0, 16, 8'h30, 1'b1);
        drive_bit(0, 1'b1, 30);
        chk("b2b_pulses", nrise[0] - b, 3);
        chk("b2b_byte0", int'(rise_byte[0][b & 15]), 8'h4C);
        chk("b2b_byte1", int'(rise_byte[0][(b + 1) & 15]), 8'h33);
        chk("b2b_byte2", int'(rise_byte[0][(b + 2) & 15]), 8'h30);
        chk("b2b_space01", rise_cyc[0][(b + 1) & 15] - rise_cyc[0][b & 15], 160);
        chk("b2b_space12", rise_cyc[0][(b + 2) & 15] - rise_cyc[0][(b + 1) & 15], 160);
        chk("b2b_width2", width[0][(b + 2) & 15], 2);

        // Glitch: 5 low cycles is rejected at the half-bit check.
        b = nrise[0];
        f = fe_rise[0];
        drive_bit(0, 1'b0, 5);
        chk("glitch_busy_high", int'(bsy[0]), 1);
        drive_bit(0, 1'b1, 11);
        chk("glitch_busy_low", int'(bsy[0]), 0);
        tick(30);
        chk("glitch_pulses", nrise[0] - b, 0);
        chk("glitch_ferr", fe_rise[0] - f, 0);
        chk("glitch_byte_out", int'(bo[0]), 8'h30);

        // Framing error followed by a long break.
        b = nrise[0];
        f = fe_rise[0];
        fc = fe_cyc[0];
        send_frame(0, 16, 8'hA5, 1'b0);
        tick(40 * 16);
        chk("brk_ferr_pulses", fe_rise[0] - f, 1);
        chk("brk_ferr_width", fe_cyc[0] - fc, 1);
        chk("brk_pulses", nrise[0] - b, 0);
        chk("brk_byte_out", int'(bo[0]), 8'h30);
        chk("brk_busy_held", int'(bsy[0]), 1);
        drive_bit(0, 1'b1, 4);
        chk("brk_busy_release", int'(bsy[0]), 0);
        tick(20);
        send_frame(0, 16, 8'h31, 1'b1);
        drive_bit(0, 1'b1, 20);
        chk("brk_next_pulses", nrise[0] - b, 1);
        chk("brk_next_byte", int'(bo[0]), 8'h31);

        // Reset during data bit 4 of 0xFF.
        b = nrise[0];
        drive_bit(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 16);
        drive_bit(0, 1'b1, 8);
        chk("midrst_busy_before", int'(bsy[0]), 1);
        rst = 1'b1;
        tick(1);
        chk("midrst_byte_out", int'(bo[0]), 0);
        chk("midrst_busy", int'(bsy[0]), 0);
        chk("midrst_avail", int'(ba[0]), 0);
        rst = 1'b0;
        drive_bit(0, 1'b1, 100);
        chk("midrst_no_byte", nrise[0] - b, 0);
        send_frame(0, 16, 8'h3F, 1'b1);
        drive_bit(0, 1'b1, 20);
        chk("midrst_next_byte", int'(bo[0]), 8'h3F);
        chk("midrst_next_pulses", nrise[0] - b, 1);

        // Minimum divisor, streamed back to back.
        b = nrise[1];
        send_frame(1, 4, 8'h00, 1'b1);
        send_frame(1, 4, 8'hFF, 1'b1);
        send_frame(1, 4, 8'h55, 1'b1);
        drive_bit(1, 1'b1, 20);
        chk("min_pulses", nrise[1] - b, 3);
        chk("min_byte0", int'(rise_byte[1][b & 15]), 8'h00);
        chk("min_byte1", int'(rise_byte[1][(b + 1) & 15]), 8'hFF);
        chk("min_byte2", int'(rise_byte[1][(b + 2) & 15]), 8'h55);
        chk("min_space", rise_cyc[1][(b + 2) & 15] - rise_cyc[1][(b + 1) & 15], 40);
        chk("min_width", width[1][(b + 1) & 15], 2);
        chk("min_gap_ge2", int'(min_gap[1] >= 2), 1);
        chk("min_ferr", fe_rise[1], 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
